// File: rtl/motion_pkg.sv
// Shared encodings for the motion sequencer: command, heading, FSM state, motor patterns.
// Pure declarations and combinational helpers; no latency.
// No handshake of its own.
package motion_pkg;

    typedef enum logic [1:0] {
        CMD_FWD   = 2'b00,
        CMD_LEFT  = 2'b01,
        CMD_RIGHT = 2'b10,
        CMD_STOP  = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        HD_N = 2'b00,
        HD_E = 2'b01,
        HD_W = 2'b10,
        HD_S = 2'b11
    } heading_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BRAKE = 2'b01,
        ST_TURN  = 2'b10,
        ST_FWD   = 2'b11
    } state_t;

    // H-bridge patterns, motor[7] = in1 ... motor[0] = in8
    localparam logic [7:0] MOT_STOP  = 8'h00;
    localparam logic [7:0] MOT_FWD   = 8'hAA;
    localparam logic [7:0] MOT_LEFT  = 8'hA5;
    localparam logic [7:0] MOT_RIGHT = 8'h5A;

    // 90 degrees counter-clockwise: N->W->S->E->N
    function automatic heading_t turn_left(input heading_t h);
        heading_t r;
        case (h)
            HD_N:    r = HD_W;
            HD_W:    r = HD_S;
            HD_S:    r = HD_E;
            default: r = HD_N;
        endcase
        return r;
    endfunction

    // 90 degrees clockwise: N->E->S->W->N
    function automatic heading_t turn_right(input heading_t h);
        heading_t r;
        case (h)
            HD_N:    r = HD_E;
            HD_E:    r = HD_S;
            HD_S:    r = HD_W;
            default: r = HD_N;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
// Latency: 2 clk edges from d to q.
// No backpressure; samples every cycle.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_d;
    logic [1:0] sync_q;

    // shift the raw input one stage down the chain
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // synchronizer flops, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/motion_sequencer.sv
// Move-command sequencer driving the four-motor H-bridge and tracking heading.
// Latency: outputs registered, phase of N cycles starts the cycle after the handshake.
// Backpressure: cmd_ready only in IDLE; cmd ignored otherwise, cmd_valid may stay high.
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int         BRAKE_CYCLES = 4,
    parameter int         TURN_CYCLES  = 50000,
    parameter int         FWD_CYCLES   = 100000,
    parameter logic [1:0] HEADING_INIT = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic       fir,
    output logic [7:0] motor,
    output logic [1:0] heading,
    output logic       turning,
    output logic       left,
    output logic       right,
    output logic       busy,
    output logic       done,
    output logic       abort
);

    localparam int MAX_BT  = (BRAKE_CYCLES > TURN_CYCLES) ? BRAKE_CYCLES : TURN_CYCLES;
    localparam int MAX_CYC = (MAX_BT > FWD_CYCLES) ? MAX_BT : FWD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] BRAKE_LOAD = CNT_W'(BRAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FWD_LOAD   = CNT_W'(FWD_CYCLES - 1);

    logic fir_s;
    cmd_t cmd_e;

    state_t           state_d,      state_q;
    logic [CNT_W-1:0] cnt_d,        cnt_q;
    logic             dir_right_d,  dir_right_q;
    logic             turn_pend_d,  turn_pend_q;
    logic             abort_pend_d, abort_pend_q;
    heading_t         heading_d,    heading_q;
    logic [7:0]       motor_d,      motor_q;
    logic             turning_d,    turning_q;
    logic             left_d,       left_q;
    logic             right_d,      right_q;
    logic             done_d,       done_q;
    logic             abort_d,      abort_q;

    sync2 u_fir_sync (
        .clk (clk),
        .rst (rst),
        .d   (fir),
        .q   (fir_s)
    );

    assign cmd_e = cmd_t'(cmd);

    // next-state, phase counter and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dir_right_d  = dir_right_q;
        turn_pend_d  = turn_pend_q;
        abort_pend_d = abort_pend_q;
        heading_d    = heading_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_e)
                        CMD_FWD: begin
                            if (fir_s) begin
                                // obstacle already in view: refuse the step outright
                                abort_d = 1'b1;
                            end else begin
                                state_d = ST_FWD;
                                cnt_d   = FWD_LOAD;
                            end
                        end
                        CMD_LEFT, CMD_RIGHT: begin
                            // every turn starts from a full stop
                            dir_right_d  = (cmd_e == CMD_RIGHT);
                            turn_pend_d  = 1'b1;
                            abort_pend_d = 1'b0;
                            state_d      = ST_BRAKE;
                            cnt_d        = BRAKE_LOAD;
                        end
                        default: begin
                            turn_pend_d  = 1'b0;
                            abort_pend_d = 1'b0;
                            state_d      = ST_BRAKE;
                            cnt_d        = BRAKE_LOAD;
                        end
                    endcase
                end
            end
            ST_BRAKE: begin
                if (cnt_q == '0) begin
                    if (turn_pend_q) begin
                        turn_pend_d = 1'b0;
                        state_d     = ST_TURN;
                        cnt_d       = TURN_LOAD;
                    end else begin
                        // brake ends either a STOP (done) or an obstacle cut (abort)
                        state_d      = ST_IDLE;
                        done_d       = ~abort_pend_q;
                        abort_d      = abort_pend_q;
                        abort_pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    heading_d = dir_right_q ? turn_right(heading_q) : turn_left(heading_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                // obstacle wins over a count expiring on the same edge
                if (fir_s) begin
                    state_d      = ST_BRAKE;
                    cnt_d        = BRAKE_LOAD;
                    abort_pend_d = 1'b1;
                    turn_pend_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase

        case (state_d)
            ST_FWD:  motor_d = MOT_FWD;
            ST_TURN: motor_d = dir_right_d ? MOT_RIGHT : MOT_LEFT;
            default: motor_d = MOT_STOP;
        endcase
        turning_d = (state_d == ST_TURN);
        left_d    = turning_d & ~dir_right_d;
        right_d   = turning_d &  dir_right_d;
    end

    // FSM state and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dir_right_q  <= 1'b0;
            turn_pend_q  <= 1'b0;
            abort_pend_q <= 1'b0;
            heading_q    <= heading_t'(HEADING_INIT);
            motor_q      <= MOT_STOP;
            turning_q    <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_right_q  <= dir_right_d;
            turn_pend_q  <= turn_pend_d;
            abort_pend_q <= abort_pend_d;
            heading_q    <= heading_d;
            motor_q      <= motor_d;
            turning_q    <= turning_d;
            left_q       <= left_d;
            right_q      <= right_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) & ~rst;
    assign busy      = (state_q != ST_IDLE);
    assign motor     = motor_q;
    assign heading   = heading_q;
    assign turning   = turning_q;
    assign left      = left_q;
    assign right     = right_q;
    assign done      = done_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with a timeline-based reference model.
module tb_motion_sequencer;

    localparam int B  = 4;
    localparam int T  = 10;
    localparam int F  = 8;
    localparam int NC = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       fir;
    logic       cmd_ready;
    logic [7:0] motor;
    logic [1:0] heading;
    logic       turning, left, right, busy, done, abort;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // expected outputs per absolute cycle (cycle n = interval after the n-th rising edge)
    logic [7:0] e_mot   [NC];
    logic [1:0] e_head  [NC];
    bit         e_busy  [NC];
    bit         e_turn  [NC];
    bit         e_left  [NC];
    bit         e_right [NC];
    bit         e_done  [NC];
    bit         e_abort [NC];
    bit         fir_h   [NC];
    bit         rst_h   [NC];
    int         fwd_hi = -1;

    motion_sequencer #(
        .BRAKE_CYCLES (B),
        .TURN_CYCLES  (T),
        .FWD_CYCLES   (F),
        .HEADING_INIT (2'b00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .fir       (fir),
        .motor     (motor),
        .heading   (heading),
        .turning   (turning),
        .left      (left),
        .right     (right),
        .busy      (busy),
        .done      (done),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // heading as quarter-turns clockwise from north
    function automatic logic [1:0] rot(input logic [1:0] h, input bit cw);
        logic [1:0] tbl [4];
        int ang;
        tbl = '{2'b00, 2'b01, 2'b11, 2'b10};
        ang = 0;
        for (int i = 0; i < 4; i++) if (tbl[i] == h) ang = i;
        ang = (ang + (cw ? 1 : 3)) % 4;
        return tbl[ang];
    endfunction

    task automatic wipe(input int from);
        for (int k = from; k < NC; k++) begin
            e_mot[k] = 8'h00; e_head[k] = 2'b00; e_busy[k] = 0; e_turn[k] = 0;
            e_left[k] = 0; e_right[k] = 0; e_done[k] = 0; e_abort[k] = 0;
        end
    endtask

    // schedule the outputs of a command accepted on the edge that ends cycle c
    task automatic accept(input int c, input logic [1:0] op, input bit fs);
        logic [1:0] nh;
        case (op)
            2'b00: begin
                if (fs) begin
                    e_abort[c+1] = 1;
                end else begin
                    for (int k = 1; k <= F; k++) begin e_busy[c+k] = 1; e_mot[c+k] = 8'hAA; end
                    e_done[c+F+1] = 1;
                    fwd_hi = c + F;
                end
            end
            2'b01, 2'b10: begin
                for (int k = 1; k <= B + T; k++) e_busy[c+k] = 1;
                for (int k = B + 1; k <= B + T; k++) begin
                    e_mot[c+k]   = (op == 2'b10) ? 8'h5A : 8'hA5;
                    e_turn[c+k]  = 1;
                    e_left[c+k]  = (op == 2'b01);
                    e_right[c+k] = (op == 2'b10);
                end
                e_done[c+B+T+1] = 1;
                nh = rot(e_head[c], op == 2'b10);
                for (int k = c + B + T + 1; k < NC; k++) e_head[k] = nh;
            end
            default: begin
                for (int k = 1; k <= B; k++) e_busy[c+k] = 1;
                e_done[c+B+1] = 1;
            end
        endcase
    endtask

    // reference model: advances once per rising edge using inputs of the cycle just ended
    initial begin
        int  c;
        bit  fs;
        wipe(0);
        forever begin
            @(posedge clk);
            c = cyc;
            if (c < NC - 40) begin
                fir_h[c] = fir;
                rst_h[c] = rst;
                if (rst) begin
                    wipe(c + 1);
                    fwd_hi = -1;
                end else begin
                    fs = (c >= 2) && fir_h[c-2] && !rst_h[c-2] && !rst_h[c-1];
                    if (fwd_hi >= 0 && c <= fwd_hi && fs) begin
                        for (int k = c + 1; k <= fwd_hi + 1; k++) begin
                            e_mot[k] = 8'h00; e_busy[k] = 0; e_done[k] = 0;
                        end
                        for (int k = c + 1; k <= c + B; k++) e_busy[k] = 1;
                        e_abort[c+B+1] = 1;
                        fwd_hi = -1;
                    end else if (!e_busy[c] && cmd_valid) begin
                        accept(c, cmd, fs);
                    end
                end
            end
            cyc = c + 1;
        end
    end

    // per-cycle compare against the model (reset values while rst is high)
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < NC - 40) begin
                if (rst) begin
                    chk("rst_motor",   int'(motor),     0);
                    chk("rst_heading", int'(heading),   0);
                    chk("rst_turning", int'(turning),   0);
                    chk("rst_busy",    int'(busy),      0);
                    chk("rst_done",    int'(done),      0);
                    chk("rst_abort",   int'(abort),     0);
                    chk("rst_ready",   int'(cmd_ready), 0);
                end else begin
                    chk("motor",   int'(motor),     int'(e_mot[cyc]));
                    chk("heading", int'(heading),   int'(e_head[cyc]));
                    chk("turning", int'(turning),   int'(e_turn[cyc]));
                    chk("left",    int'(left),      int'(e_left[cyc]));
                    chk("right",   int'(right),     int'(e_right[cyc]));
                    chk("busy",    int'(busy),      int'(e_busy[cyc]));
                    chk("ready",   int'(cmd_ready), int'(!e_busy[cyc]));
                    chk("done",    int'(done),      int'(e_done[cyc]));
                    chk("abort",   int'(abort),     int'(e_abort[cyc]));
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // present a command and return the cycle whose closing edge accepted it
    task automatic send(input logic [1:0] c, output int acc);
        bit got;
        got = 0;
        acc = -1;
        cmd_valid = 1'b1;
        cmd = c;
        for (int i = 0; i < 100 && !got; i++) begin
            if (cmd_ready) begin
                got = 1;
                acc = cyc;
            end
            @(posedge clk);
            #2;
        end
        if (!got) chk("handshake_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        int a, prev;
        logic [1:0] hs [4];
        hs = '{2'b10, 2'b11, 2'b01, 2'b00};
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; fir = 1'b0;
        @(posedge clk); #2;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
        chk("init_motor", int'(motor), 0);
        chk("init_heading", int'(heading), 0);
        chk("init_ready", int'(cmd_ready), 1);

        // RIGHT: 4 brake cycles, 10 turn cycles, then done with heading E
        send(2'b10, a);
        cmd_valid = 1'b0;
        chk("right_brake_motor", int'(motor), 'h00);
        wait_cyc(4);
        chk("right_turn_motor", int'(motor), 'h5A);
        chk("right_flag", int'(right), 1);
        wait_cyc(10);
        chk("right_done", int'(done), 1);
        chk("right_heading", int'(heading), 'b01);

        // four back-to-back LEFTs with cmd_valid held
        do_reset();
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            send(2'b01, a);
            if (i > 0) chk("left_gap", a - prev, 15);
            prev = a;
            wait_cyc(14);
            chk("left_done", int'(done), 1);
            chk("left_heading", int'(heading), int'(hs[i]));
        end
        cmd_valid = 1'b0;

        // FWD cut short by an obstacle raised in cycle 3
        do_reset();
        send(2'b00, a);
        cmd_valid = 1'b0;
        wait_cyc(2);
        fir = 1'b1;
        wait_cyc(2);
        chk("fwd_motor_c5", int'(motor), 'hAA);
        wait_cyc(1);
        chk("fwd_motor_c6", int'(motor), 'h00);
        chk("fwd_busy_c6", int'(busy), 1);
        wait_cyc(3);
        chk("fwd_nodone_c9", int'(done), 0);
        wait_cyc(1);
        chk("fwd_abort_c10", int'(abort), 1);
        chk("fwd_nodone_c10", int'(done), 0);
        fir = 1'b0;
        wait_cyc(3);

        // FWD refused while the obstacle is already present
        fir = 1'b1;
        wait_cyc(3);
        send(2'b00, a);
        cmd_valid = 1'b0;
        chk("blk_abort", int'(abort), 1);
        chk("blk_motor", int'(motor), 0);
        chk("blk_ready", int'(cmd_ready), 1);
        chk("blk_busy", int'(busy), 0);
        fir = 1'b0;
        wait_cyc(4);

        // reset in the fifth TURN cycle of a LEFT
        send(2'b01, a);
        cmd_valid = 1'b0;
        wait_cyc(8);
        chk("mid_turning", int'(turning), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_motor", int'(motor), 0);
        chk("mid_rst_turning", int'(turning), 0);
        chk("mid_rst_heading", int'(heading), 0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(3);
        chk("post_rst_heading", int'(heading), 0);
        chk("post_rst_busy", int'(busy), 0);

        // STOP from IDLE
        send(2'b11, a);
        cmd_valid = 1'b0;
        chk("stop_busy", int'(busy), 1);
        wait_cyc(3);
        chk("stop_busy_c4", int'(busy), 1);
        wait_cyc(1);
        chk("stop_done", int'(done), 1);
        chk("stop_heading", int'(heading), 0);
        wait_cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
